tcb_lib_arbiter: RTL
====================

Name: tcb_lib_arbiter

Overview:
- Round-robin arbiter sharing one TCB subordinate port between MPN TCB managers.
- Sits between several bus initiators (CPU fetch, CPU load/store, DMA) and a single memory or peripheral path, typically ahead of a backpressure register slice.
- Selects one request per cycle and forwards it downstream.
- Tracks ownership of in-flight transfers so each response, returned DLY cycles after its transfer, is routed back to the manager that issued it.

Parameters:
- MPN, 2, number of manager (requester) ports; range 2..16.
- DLY, 1, fixed response delay of the downstream subordinate in cycles; range 0..8.
- ADR, 32, address width.
- DAT, 32, data width; BEN = DAT/8 byte enables.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- sub_vld  in  MPN  per-requester request valid
- sub_wen  in  MPN  per-requester write enable (0 = read)
- sub_lck  in  MPN  per-requester arbitration lock (used only with the optional feature)
- sub_adr  in  MPN*ADR  packed addresses, requester i at [i*ADR +: ADR]
- sub_ben  in  MPN*BEN  packed byte enables
- sub_wdt  in  MPN*DAT  packed write data
- sub_rdy  out  MPN  per-requester ready, one-hot or zero
- sub_rsp  out  MPN  per-requester response strobe, one-hot or zero
- sub_rdt  out  DAT  read data, broadcast to all requesters
- sub_err  out  1  error response, broadcast to all requesters
- man_vld  out  1  downstream request valid
- man_wen  out  1  downstream write enable
- man_adr  out  ADR  downstream address
- man_ben  out  BEN  downstream byte enables
- man_wdt  out  DAT  downstream write data
- man_rdy  in  1  downstream ready
- man_rdt  in  DAT  downstream read data
- man_err  in  1  downstream error

Behaviour:
- Handshake: a transfer occurs on a cycle with vld & rdy. A manager holds vld and its payload stable until rdy.
- Grant selection (combinational): the first requester with sub_vld=1, searching from index ptr upward with wrap MPN-1 to 0.
- Request path:
  - man_vld = |sub_vld.
  - man_wen/adr/ben/wdt are muxed from the granted requester; all-zero when no request is valid.
  - sub_rdy[g] = man_rdy for the granted index g; all other sub_rdy = 0.
  - No added latency on the request path.
- Priority pointer ptr (clog2(MPN) bits, reset 0): on each man transfer, ptr <= (g+1) mod MPN; otherwise it holds. Wrap from MPN-1 goes to 0.
- Fairness: a continuously requesting manager waits at most MPN-1 transfers.
- Ownership pipeline: DLY-stage shift register of {valid, index}.
  - Stage 0 loads {man_vld & man_rdy, g} every cycle.
  - All stages shift each clk.
  - Reset: all valid bits 0, indices 0.
- Response routing:
  - DLY>0: sub_rsp[idx] = valid of the last stage. sub_rdt = man_rdt and sub_err = man_err, passed through combinationally.
  - DLY=0: sub_rsp[g] = man_vld & man_rdy in the same cycle; no storage is instantiated.
- Back-to-back transfers from different managers in consecutive cycles are supported with full throughput; responses come back in issue order.
- man_rdy=0 with several requesters valid: the grant holds (ptr is unchanged) and the payload stays stable, so the grant does not change mid-stall.
- Reset asserted mid-operation:
  - In-flight responses are discarded and no sub_rsp is generated for them.
  - ptr returns to 0.
  - Outputs are combinational from inputs and state, so after reset sub_rdy/sub_rsp = 0 unless inputs request.

Optional Feature:
- Macro: TCB_LIB_ARBITER_LOCK_EN.
- Enabled:
  - A 1-bit lock register (reset 0) plus a lock owner index are added.
  - A transfer with sub_lck[g]=1 sets lock and records g as owner.
  - While lock=1, only the owner can be granted; other requesters are masked.
  - Lock clears on a transfer from the owner with sub_lck=0.
  - Used for atomic read-modify-write sequences.
- Disabled: sub_lck is ignored and no lock state exists.

Decomposition:
- Package tcb_lib_arbiter_pkg holds:
  - function rr_select (rotating priority select over a vld vector and ptr),
  - typedef tcb_arb_own_t {logic vld; logic [IDW-1:0] idx;},
  - the IDW = clog2(MPN) derivation.
- One sub-module: tcb_lib_arbiter_tracker, the DLY-stage ownership shift register with a generate bypass for DLY=0.

Test Plan:
- MPN=2, DLY=1, only sub_vld[0]=1, writing adr 0x10, wdt 0x01234567, man_rdy=1 -> transfer in cycle 1, man_adr=0x10; sub_rsp[0]=1 in cycle 2 only.
- Both managers valid every cycle, man_rdy=1, 6 cycles -> grant sequence 0,1,0,1,0,1; each sub_rsp strobe follows its transfer by exactly 1 cycle.
- DLY=2, req0 reads 0x20, then req1 reads 0x24 back-to-back; memory returns 0xAAAA0000 then 0xBBBB0000 -> sub_rsp[0] with 0xAAAA0000 at t+2, sub_rsp[1] with 0xBBBB0000 at t+3.
- man_rdy=0 for 3 cycles with both managers valid, ptr=1 -> grant stays at 1 and man_adr stable; ptr becomes 0 after the transfer.
- Reset asserted while a DLY=2 response is in flight -> no sub_rsp after reset release; the first grant goes to index 0.
- LOCK_EN: req0 issues two transfers with sub_lck=1, then one with sub_lck=0, while req1 is continuously valid -> req1 is first granted on the cycle after req0's unlocking transfer.

Source files
------------

// File: rtl/tcb_lib_arbiter_pkg.sv
// Shared types and helpers for the TCB round-robin arbiter.
// The index types are sized for the largest supported manager count (16),
// so one struct/function definition serves every MPN instance.
package tcb_lib_arbiter_pkg;

  // Largest supported number of manager ports and the index width it needs.
  localparam int MPN_MAX = 16;
  localparam int IDW_MAX = 4;

  // Manager index, wide enough for any supported MPN.
  typedef logic [IDW_MAX-1:0] arb_idx_t;

  // Ownership record of one in-flight transfer: valid flag plus the
  // index of the manager that issued it.
  typedef struct packed {
    logic     vld;
    arb_idx_t idx;
  } tcb_arb_own_t;

  // IDW = clog2(MPN), kept at least 1 bit so a 2-port pointer is legal.
  function automatic int tcb_arb_idw(input int mpn);
    return (mpn <= 2) ? 1 : $clog2(mpn);
  endfunction

  // Rotating-priority select: the first set bit of vld at or above ptr,
  // wrapping from mpn-1 back to 0. Result is {found, index}.
  function automatic logic [IDW_MAX:0] rr_select(
    input logic [MPN_MAX-1:0] vld,
    input int                 mpn,
    input arb_idx_t           ptr
  );
    logic     found;
    arb_idx_t sel;
    int       pos;
    found = 1'b0;
    sel   = '0;
    pos   = 0;
    for (int k = 0; k < MPN_MAX; k++) begin
      if (k < mpn) begin
        pos = int'(ptr) + k;
        if (pos >= mpn) pos = pos - mpn;
        if (!found && vld[pos[IDW_MAX-1:0]]) begin
          found = 1'b1;
          sel   = pos[IDW_MAX-1:0];
        end
      end
    end
    return {found, sel};
  endfunction

endpackage

// File: rtl/tcb_lib_arbiter_tracker.sv
// Ownership tracker: a DLY-stage shift register of {valid, index} that
// remembers which manager issued each transfer, so the response arriving
// DLY cycles later can be steered back to it. DLY=0 is a pure wire.
module tcb_lib_arbiter_tracker
  import tcb_lib_arbiter_pkg::*;
#(
  parameter int DLY = 1
)(
  input  logic     clk,
  input  logic     rst,
  input  logic     xfer,
  input  arb_idx_t own_idx,
  output logic     rsp_vld,
  output arb_idx_t rsp_idx
);

  generate
    if (DLY == 0) begin : g_bypass
      // Response arrives in the transfer cycle; nothing to remember.
      assign rsp_vld = xfer;
      assign rsp_idx = own_idx;

      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
    end else begin : g_pipe
      tcb_arb_own_t own_q [DLY];

      // Load the current transfer into stage 0 and shift older ones along;
      // reset drops every in-flight record so no stale response is routed.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < DLY; k++) begin
            own_q[k] <= '0;
          end
        end else begin
          own_q[0].vld <= xfer;
          own_q[0].idx <= own_idx;
          for (int k = 1; k < DLY; k++) begin
            own_q[k] <= own_q[k-1];
          end
        end
      end

      assign rsp_vld = own_q[DLY-1].vld;
      assign rsp_idx = own_q[DLY-1].idx;
    end
  endgenerate

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate between MPN managers.
// The request path is purely combinational (no added latency); the
// response path uses an ownership tracker matched to the downstream delay.
//
// Handshake: a transfer happens on any cycle with vld & rdy. A manager
// keeps vld and its payload stable until it sees rdy; the grant cannot
// move while man_rdy is low because the pointer only advances on a transfer.
//
// Optional macro TCB_LIB_ARBITER_LOCK_EN adds an arbitration lock for
// atomic sequences: a transfer with sub_lck=1 pins the grant to its
// manager until that manager completes a transfer with sub_lck=0.
module tcb_lib_arbiter
  import tcb_lib_arbiter_pkg::*;
#(
  parameter  int MPN = 2,
  parameter  int DLY = 1,
  parameter  int ADR = 32,
  parameter  int DAT = 32,
  localparam int BEN = DAT/8
)(
  input  logic             clk,
  input  logic             rst,
  // manager-facing side
  input  logic [MPN-1:0]     sub_vld,
  input  logic [MPN-1:0]     sub_wen,
  input  logic [MPN-1:0]     sub_lck,
  input  logic [MPN*ADR-1:0] sub_adr,
  input  logic [MPN*BEN-1:0] sub_ben,
  input  logic [MPN*DAT-1:0] sub_wdt,
  output logic [MPN-1:0]     sub_rdy,
  output logic [MPN-1:0]     sub_rsp,
  output logic [DAT-1:0]     sub_rdt,
  output logic               sub_err,
  // subordinate-facing side
  output logic               man_vld,
  output logic               man_wen,
  output logic [ADR-1:0]     man_adr,
  output logic [BEN-1:0]     man_ben,
  output logic [DAT-1:0]     man_wdt,
  input  logic               man_rdy,
  input  logic [DAT-1:0]     man_rdt,
  input  logic               man_err
);

  localparam int IDW = tcb_arb_idw(MPN);

  logic [IDW-1:0]     ptr;
  logic [MPN-1:0]     vld_eff;
  logic [IDW_MAX:0]   sel;
  logic               gnt_any;
  arb_idx_t           gnt;
  logic               xfer;
  logic               rsp_vld;
  arb_idx_t           rsp_idx;

`ifdef TCB_LIB_ARBITER_LOCK_EN
  logic     lock;
  arb_idx_t lock_own;
  logic     lck_g;

  // While locked, only the owner's request is visible to the selector.
  always_comb begin
    vld_eff = '0;
    for (int i = 0; i < MPN; i++) begin
      vld_eff[i] = sub_vld[i] & (~lock | (lock_own == arb_idx_t'(i)));
    end
  end

  // Lock request of the currently granted manager.
  always_comb begin
    lck_g = 1'b0;
    for (int i = 0; i < MPN; i++) begin
      if (gnt_any && (gnt == arb_idx_t'(i))) begin
        lck_g = sub_lck[i];
      end
    end
  end

  // Set the lock on a locked transfer, release it on the owner's
  // first unlocked transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock     <= 1'b0;
      lock_own <= '0;
    end else if (xfer) begin
      if (lck_g) begin
        lock     <= 1'b1;
        lock_own <= gnt;
      end else if (lock && (gnt == lock_own)) begin
        lock     <= 1'b0;
      end
    end
  end
`else
  // Without the lock feature every request competes on equal terms.
  always_comb begin
    vld_eff = sub_vld;
  end

  logic unused_lck;
  assign unused_lck = &{1'b0, sub_lck};
`endif

  // Rotating-priority grant starting at ptr.
  always_comb begin
    sel     = rr_select(MPN_MAX'(vld_eff), MPN, arb_idx_t'(ptr));
    gnt_any = sel[IDW_MAX];
    gnt     = sel[IDW_MAX-1:0];
  end

  assign man_vld = gnt_any;
  assign xfer    = man_vld & man_rdy;

  // Forward the granted payload; drive zeros when nobody requests.
  always_comb begin
    man_wen = 1'b0;
    man_adr = '0;
    man_ben = '0;
    man_wdt = '0;
    sub_rdy = '0;
    for (int i = 0; i < MPN; i++) begin
      if (gnt_any && (gnt == arb_idx_t'(i))) begin
        man_wen    = sub_wen[i];
        man_adr    = sub_adr[i*ADR +: ADR];
        man_ben    = sub_ben[i*BEN +: BEN];
        man_wdt    = sub_wdt[i*DAT +: DAT];
        sub_rdy[i] = man_rdy;
      end
    end
  end

  // Advance the priority pointer past the winner on every transfer;
  // holding it otherwise keeps the grant stable through a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer) begin
      if (gnt == arb_idx_t'(MPN-1)) begin
        ptr <= '0;
      end else begin
        ptr <= IDW'(gnt + arb_idx_t'(1));
      end
    end
  end

  tcb_lib_arbiter_tracker #(
    .DLY (DLY)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .xfer    (xfer),
    .own_idx (gnt),
    .rsp_vld (rsp_vld),
    .rsp_idx (rsp_idx)
  );

  // Steer the response strobe to the manager that issued the transfer.
  always_comb begin
    sub_rsp = '0;
    for (int i = 0; i < MPN; i++) begin
      sub_rsp[i] = rsp_vld && (rsp_idx == arb_idx_t'(i));
    end
  end

  // Read data and error are broadcast; only the strobed manager consumes them.
  assign sub_rdt = man_rdt;
  assign sub_err = man_err;

endmodule
